uart_command_rx: RTL
====================

UART_COMMAND_RX -- requirements
Module: uart_command_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 100_000_000, board clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate in bits per second.
REQ-003 SHALL have port clk, input, 1 bit, the only clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port rx, input, 1 bit, asynchronous serial line from usb_rx; idle high.
REQ-006 SHALL have port data, output, 8 bits, last correctly framed byte.
REQ-007 SHALL have port data_valid, output, 1 bit, one-cycle pulse when data updates.
REQ-008 SHALL have port frame_err, output, 1 bit, one-cycle pulse on a bad stop bit.
REQ-009 SHALL have port cmd_start, output, 1 bit, one-cycle pulse on a start command.
REQ-010 SHALL have port cmd_stop, output, 1 bit, one-cycle pulse on a stop command.
REQ-011 SHALL have port cmd_clear, output, 1 bit, one-cycle pulse on a clear command.
REQ-012 SHALL have port run, output, 1 bit, level run-enable for the stopwatch counters.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer whose flops reset to 1; all further logic uses only the synchronized signal (rx_s).
REQ-014 SHALL derive CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE with integer truncation (868 at defaults) and HALF_BIT = CLKS_PER_BIT / 2 (434).
REQ-015 SHALL implement states IDLE, START, DATA, STOP and WAIT_HIGH.
REQ-016 IDLE -> START when rx_s = 0; the bit timer is cleared on entry.
REQ-017 START SHALL sample rx_s after HALF_BIT cycles: 0 -> DATA; 1 -> IDLE, treated as a glitch with no output pulse.
REQ-018 DATA SHALL sample rx_s every CLKS_PER_BIT cycles, 8 samples, LSB first, into a shift register, then go to STOP.
REQ-019 STOP SHALL sample rx_s after CLKS_PER_BIT cycles:
- 1: data is loaded, data_valid pulses on the next cycle, and the state returns to IDLE.
- 0: frame_err pulses, data is unchanged, and the state goes to WAIT_HIGH.
REQ-020 WAIT_HIGH SHALL remain until rx_s = 1, then go to IDLE, so a break condition produces no further frames.
REQ-021 Command decode SHALL occur only on a valid byte; command pulses are coincident with data_valid.
- 0x53 'S' or 0x73 's': cmd_start pulses and run is set to 1.
- 0x50 'P' or 0x70 'p': cmd_stop pulses and run is cleared to 0.
- 0x52 'R' or 0x72 'r': cmd_clear pulses and run is cleared to 0.
- Any other byte: data_valid only; run is unchanged.
REQ-022 A repeated command SHALL re-pulse its output; run is idempotent.
REQ-023 Back-to-back frames with exactly one stop bit SHALL be received with no loss, because the start bit is detected in IDLE on the cycle after the stop sample.
REQ-024 At most one of cmd_start, cmd_stop or cmd_clear SHALL be high in any cycle; frame_err and data_valid are never high together.

Reset
REQ-025 On rst SHALL force the following, asynchronously and regardless of state, including mid-frame:
- state = IDLE;
- synchronizer flops = 1;
- data = 0x00, run = 0;
- all pulse outputs = 0;
- timer and bit count = 0.
REQ-026 After rst deasserts, the first falling edge on rx_s SHALL begin a fresh frame.

Structure
REQ-027 Shared package stopwatch_pkg SHALL hold the state enum and the six ASCII command constants.
REQ-028 The bit timer SHALL be the single sub-module uart_bit_timer, with parameterized terminal count, clear input and done pulse output; everything else is inline.

Verification (defaults; t0 = first cycle rx_s is low)
REQ-029 Send 0x73 -> data = 0x73, with data_valid, cmd_start and run = 1 asserted at t0 + 8247; no other pulses.
REQ-030 Hold rx low for 200 cycles, then high -> no data_valid, no frame_err, and the state is back in IDLE.
REQ-031 Send 0x41 with stop bit = 0 and hold low for 20000 cycles -> exactly one frame_err and data unchanged; then send 0x70 -> cmd_stop and run = 0.
REQ-032 With run = 1, send 0x78 then 0x52 back to back -> data_valid with data = 0x78 and run still 1; then cmd_clear with run = 0, 8680 cycles apart.
REQ-033 Assert rst at bit 4 of a frame -> all outputs 0 within the same cycle; the next full frame 0x53 is received correctly.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch UART command receiver.
// Holds the receiver state encoding and the ASCII command bytes.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_e;

    typedef enum logic [1:0] {
        CMD_NONE,
        CMD_GO,
        CMD_HALT,
        CMD_ZERO
    } cmd_e;

    localparam logic [7:0] CMD_START_UC = 8'h53;
    localparam logic [7:0] CMD_START_LC = 8'h73;
    localparam logic [7:0] CMD_STOP_UC  = 8'h50;
    localparam logic [7:0] CMD_STOP_LC  = 8'h70;
    localparam logic [7:0] CMD_CLEAR_UC = 8'h52;
    localparam logic [7:0] CMD_CLEAR_LC = 8'h72;

    // Map a received byte onto the command it carries, if any.
    function automatic cmd_e decode_cmd(input logic [7:0] b);
        cmd_e c;
        unique case (b)
            CMD_START_UC, CMD_START_LC: c = CMD_GO;
            CMD_STOP_UC,  CMD_STOP_LC:  c = CMD_HALT;
            CMD_CLEAR_UC, CMD_CLEAR_LC: c = CMD_ZERO;
            default:                    c = CMD_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with clear and two terminal counts.
// 'half' selects the half-bit count used to centre on the start bit.
module uart_bit_timer #(
    parameter int FULL_CNT = 868,
    parameter int HALF_CNT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic half,
    output logic done
);

    localparam int W = $clog2(FULL_CNT + 1);
    localparam logic [W-1:0] FULL_TC = W'(FULL_CNT - 1);
    localparam logic [W-1:0] HALF_TC = W'(HALF_CNT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic [W-1:0] term;

    // Next count: wrap on terminal, hold at zero while cleared.
    always_comb begin
        term  = half ? HALF_TC : FULL_TC;
        done  = 1'b0;
        cnt_d = cnt_q + W'(1);
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == term) begin
            done  = 1'b1;
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_command_rx.sv
// 8N1 UART receiver that decodes stopwatch start/stop/clear commands.
// Outputs are registered; command pulses coincide with data_valid.
module uart_command_rx
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       cmd_start,
    output logic       cmd_stop,
    output logic       cmd_clear,
    output logic       run
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;

    logic      rx_meta_q;
    logic      rx_s_q;

    rx_state_e state_q,      state_d;
    logic [7:0] shift_q,     shift_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [7:0] data_q,      data_d;
    logic      data_valid_q, data_valid_d;
    logic      frame_err_q,  frame_err_d;
    logic      cmd_start_q,  cmd_start_d;
    logic      cmd_stop_q,   cmd_stop_d;
    logic      cmd_clear_q,  cmd_clear_d;
    logic      run_q,        run_d;

    logic      tmr_clear;
    logic      tmr_half;
    logic      tmr_done;

    uart_bit_timer #(
        .FULL_CNT (CLKS_PER_BIT),
        .HALF_CNT (HALF_BIT)
    ) u_bit_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (tmr_clear),
        .half  (tmr_half),
        .done  (tmr_done)
    );

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame FSM next-state, shift register and output pulses.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        run_d        = run_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        cmd_start_d  = 1'b0;
        cmd_stop_d   = 1'b0;
        cmd_clear_d  = 1'b0;
        tmr_clear    = 1'b0;
        tmr_half     = (state_q == START);

        unique case (state_q)
            IDLE: begin
                tmr_clear = 1'b1;
                bit_cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (tmr_done) begin
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tmr_done) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tmr_done) begin
                    if (rx_s_q) begin
                        data_d       = shift_q;
                        data_valid_d = 1'b1;
                        state_d      = IDLE;
                        unique case (decode_cmd(shift_q))
                            CMD_GO: begin
                                cmd_start_d = 1'b1;
                                run_d       = 1'b1;
                            end
                            CMD_HALT: begin
                                cmd_stop_d = 1'b1;
                                run_d      = 1'b0;
                            end
                            CMD_ZERO: begin
                                cmd_clear_d = 1'b1;
                                run_d       = 1'b0;
                            end
                            default: begin
                            end
                        endcase
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                tmr_clear = 1'b1;
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            cmd_start_q  <= 1'b0;
            cmd_stop_q   <= 1'b0;
            cmd_clear_q  <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            cmd_start_q  <= cmd_start_d;
            cmd_stop_q   <= cmd_stop_d;
            cmd_clear_q  <= cmd_clear_d;
            run_q        <= run_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign cmd_start  = cmd_start_q;
    assign cmd_stop   = cmd_stop_q;
    assign cmd_clear  = cmd_clear_q;
    assign run        = run_q;

endmodule
